// File: rtl/arbitro_alu_if.sv
// Bus between the two requesters, the arbiter and the shared ALU.
// slave: arbiter view; master: requester/ALU view.
interface arbitro_alu_if #(
  parameter int ANCHO = 32
);
  logic             r0_valid, r1_valid;
  logic             r0_ready, r1_ready;
  logic [ANCHO-1:0] r0_valA, r0_valB, r1_valA, r1_valB;
  logic [3:0]       r0_operacion, r1_operacion;
  logic             r0_rsp_valid, r1_rsp_valid;
  logic             r0_rsp_ready, r1_rsp_ready;
  logic [ANCHO-1:0] r0_resultado, r1_resultado;
  logic [ANCHO-1:0] alu_valA, alu_valB, alu_resultado;
  logic [3:0]       alu_operacion;
  logic             ocupado;
  logic [15:0]      contador_ops;

  modport slave (
    input  r0_valid, r1_valid, r0_valA, r0_valB, r1_valA, r1_valB,
           r0_operacion, r1_operacion, r0_rsp_ready, r1_rsp_ready, alu_resultado,
    output r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_resultado, r1_resultado,
           alu_valA, alu_valB, alu_operacion, ocupado, contador_ops
  );

  modport master (
    output r0_valid, r1_valid, r0_valA, r0_valB, r1_valA, r1_valB,
           r0_operacion, r1_operacion, r0_rsp_ready, r1_rsp_ready, alu_resultado,
    input  r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_resultado, r1_resultado,
           alu_valA, alu_valB, alu_operacion, ocupado, contador_ops
  );
endinterface

// File: rtl/arbitro_alu.sv
// Two-requester arbiter in front of a shared combinational ALU, one op in flight.
// Define ARBITRO_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0 always wins.
module arbitro_alu #(
  parameter int ANCHO = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  arbitro_alu_if.slave  bus
);
  typedef enum logic [1:0] {LIBRE, EJEC, RESP} estado_t;

  estado_t                estado, estado_sig;
  logic [1:0]             req_vld, req_rsp_rdy, gnt;
  logic [1:0][ANCHO-1:0]  req_a, req_b;
  logic [1:0][3:0]        req_op;
  logic                   dueno, ptr, acepta, entrega;
  logic [ANCHO-1:0]       a_q, b_q, res_q;
  logic [3:0]             op_q;
  logic [15:0]            cnt_q;

  assign req_vld     = {bus.r1_valid, bus.r0_valid};
  assign req_rsp_rdy = {bus.r1_rsp_ready, bus.r0_rsp_ready};
  assign req_a       = {bus.r1_valA, bus.r0_valA};
  assign req_b       = {bus.r1_valB, bus.r0_valB};
  assign req_op      = {bus.r1_operacion, bus.r0_operacion};

  assign acepta  = |gnt;
  assign entrega = (estado == RESP) && req_rsp_rdy[dueno];

`ifdef ARBITRO_ROUND_ROBIN_EN
  // Tie priority goes to whoever was not served by the last completed op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= 1'b0;
    else if (entrega) ptr <= ~dueno;
  end
`else
  assign ptr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= LIBRE;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    gnt        = '0;
    case (estado)
      LIBRE: begin
        if (req_vld[0] && (!req_vld[1] || !ptr)) gnt[0] = 1'b1;
        else if (req_vld[1])                     gnt[1] = 1'b1;
        if (|gnt) estado_sig = EJEC;
      end
      EJEC:    estado_sig = RESP;
      RESP:    if (req_rsp_rdy[dueno]) estado_sig = LIBRE;
      default: estado_sig = LIBRE;
    endcase
    // ready must read 0 while reset is held, even with valid high
    if (!rst_n) gnt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      dueno <= 1'b0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      if (acepta) begin
        a_q   <= req_a[gnt[1]];
        b_q   <= req_b[gnt[1]];
        op_q  <= req_op[gnt[1]];
        dueno <= gnt[1];
      end
      if (estado == EJEC) res_q <= bus.alu_resultado;
      if (entrega && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.r0_ready      = gnt[0];
  assign bus.r1_ready      = gnt[1];
  assign bus.r0_rsp_valid  = (estado == RESP) && !dueno;
  assign bus.r1_rsp_valid  = (estado == RESP) &&  dueno;
  assign bus.r0_resultado  = res_q;
  assign bus.r1_resultado  = res_q;
  assign bus.alu_valA      = a_q;
  assign bus.alu_valB      = b_q;
  assign bus.alu_operacion = op_q;
  assign bus.ocupado       = (estado != LIBRE);
  assign bus.contador_ops  = cnt_q;
endmodule
